// File: rtl/code_histogram.sv
`default_nettype none
// ============================================================================
//  Module   : code_histogram
//  Purpose  : ADC code histogram. Pulls codes from an upstream FIFO, keeps
//             one counter per code (2^WIDTH bins) and reads the bins out
//             over a valid/ready stream. Counts survive readout.
//  Ports    : clk, Reset_n        - clock, async active-low reset
//             Start/Stop          - begin / end acquisition (1-cycle pulses)
//             Dump/Clear          - bin readout / zero all bins (pulses)
//             FifoEmpty, FifoRdEnable, FifoRdData - upstream FIFO
//                                   (data valid one cycle after the enable)
//             BinAddr/BinData/BinValid/BinReady - readout stream
//             Busy                - high in every state except IDLE
//             Overflow            - sticky bin saturation flag
//             TotalCount          - samples counted since last CLEAR
//  Options  : HIST_SATURATE_EN    - bins saturate at 2^CNT_WIDTH-1 and set
//                                   Overflow; otherwise bins wrap and
//                                   Overflow is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module code_histogram #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 Dump,
    input  logic                 Clear,
    input  logic                 FifoEmpty,
    output logic                 FifoRdEnable,
    input  logic [WIDTH-1:0]     FifoRdData,
    output logic [WIDTH-1:0]     BinAddr,
    output logic [CNT_WIDTH-1:0] BinData,
    output logic                 BinValid,
    input  logic                 BinReady,
    output logic                 Busy,
    output logic                 Overflow,
    output logic [31:0]          TotalCount
);

    localparam int NBINS = 1 << WIDTH;

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ACQ   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [WIDTH-1:0]     clr_ptr_q, clr_ptr_d;
    logic [WIDTH:0]       dmp_ptr_q, dmp_ptr_d;   // MSB set once every bin has been loaded
    logic                 bin_valid_q, bin_valid_d;
    logic [WIDTH-1:0]     bin_addr_q, bin_addr_d;
    logic [CNT_WIDTH-1:0] bin_data_q, bin_data_d;
    logic [31:0]          total_q, total_d;

    // Update pipeline: s1 = code on FifoRdData, s2 = read-modify-write,
    // last = value written on the previous edge (forwarding source).
    logic                 s1_vld_q;
    logic                 s2_vld_q;
    logic [WIDTH-1:0]     s2_addr_q;
    logic [CNT_WIDTH-1:0] rd_q;
    logic                 last_vld_q;
    logic [WIDTH-1:0]     last_addr_q;
    logic [CNT_WIDTH-1:0] last_data_q;

    logic [CNT_WIDTH-1:0] mem [NBINS];

    logic [CNT_WIDTH-1:0] w_base;
    logic [CNT_WIDTH-1:0] w_upd;

    // The registered read of a bin happens on the same edge as the write of
    // the previous sample, so it misses that write when both hit the same
    // bin. Older writes are already visible in the array.
    assign w_base = (last_vld_q && (last_addr_q == s2_addr_q)) ? last_data_q : rd_q;

`ifdef HIST_SATURATE_EN
    logic ovf_q;
    logic w_sat;

    assign w_sat    = &w_base;
    assign w_upd    = w_sat ? w_base : w_base + 1'b1;
    assign Overflow = ovf_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            ovf_q <= 1'b0;
        end else if (s2_vld_q && w_sat) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign w_upd    = w_base + 1'b1;
    assign Overflow = 1'b0;
`endif

    // Stop must drop the read enable in the very cycle it arrives.
    assign FifoRdEnable = (state_q == S_ACQ) && !FifoEmpty && !Stop;
    assign Busy         = (state_q != S_IDLE);
    assign BinValid     = bin_valid_q;
    assign BinAddr      = bin_addr_q;
    assign BinData      = bin_data_q;
    assign TotalCount   = total_q;

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        dmp_ptr_d   = dmp_ptr_q;
        bin_valid_d = bin_valid_q;
        bin_addr_d  = bin_addr_q;
        bin_data_d  = bin_data_q;
        total_d     = total_q;

        if (s2_vld_q) begin
            total_d = total_q + 32'd1;
        end

        case (state_q)
            S_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                total_d   = '0;
                if (clr_ptr_q == {WIDTH{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (Clear) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end else if (Dump) begin
                    state_d   = S_DUMP;
                    dmp_ptr_d = '0;
                end else if (Start) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (Stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = S_IDLE;
                end
            end
            S_DUMP: begin
                if (bin_valid_q && BinReady && dmp_ptr_q[WIDTH]) begin
                    bin_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (!dmp_ptr_q[WIDTH] && (!bin_valid_q || BinReady)) begin
                    bin_valid_d = 1'b1;
                    bin_addr_d  = dmp_ptr_q[WIDTH-1:0];
                    bin_data_d  = mem[dmp_ptr_q[WIDTH-1:0]];
                    dmp_ptr_d   = dmp_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_CLEAR;
            clr_ptr_q   <= '0;
            dmp_ptr_q   <= '0;
            bin_valid_q <= 1'b0;
            bin_addr_q  <= '0;
            bin_data_q  <= '0;
            total_q     <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_addr_q   <= '0;
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            dmp_ptr_q   <= dmp_ptr_d;
            bin_valid_q <= bin_valid_d;
            bin_addr_q  <= bin_addr_d;
            bin_data_q  <= bin_data_d;
            total_q     <= total_d;
            s1_vld_q    <= FifoRdEnable;
            s2_vld_q    <= s1_vld_q;
            if (s1_vld_q) begin
                s2_addr_q <= FifoRdData;
            end
            last_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                last_addr_q <= s2_addr_q;
                last_data_q <= w_upd;
            end
        end
    end

    // Bin storage: no reset, contents are defined by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_ptr_q] <= '0;
        end else if (s2_vld_q) begin
            mem[s2_addr_q] <= w_upd;
        end
        rd_q <= mem[FifoRdData];
    end

endmodule
`default_nettype wire
